// File: rtl/uart_pkg.sv
// Shared defaults, state encodings and frame constants for the UART pair.
package uart_pkg;

  localparam int unsigned DEF_DATA_BITS  = 8;
  localparam int unsigned DEF_OVERSAMPLE = 8;

  // Clock cycles per frame at the default settings: start + data + stop.
  localparam int unsigned FRAME_CYCLES = (DEF_DATA_BITS + 2) * DEF_OVERSAMPLE;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_receiver.sv
// 8N1 deserialiser with 2-FF input synchroniser and mid-bit sampling.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = DEF_DATA_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err
);

  localparam int unsigned PW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [PW-1:0] PH_LAST   = PW'(OVERSAMPLE - 1);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(OVERSAMPLE / 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 r_s1;
  logic                 r_s2;
  logic                 r_prev;
  rx_state_t            r_state;
  logic [PW-1:0]        r_phase;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 w_rx_s;
  logic                 w_sample;

  assign w_rx_s   = r_s2;
  assign w_sample = (r_phase == PH_SAMPLE);

  // Two-stage synchroniser plus one delayed copy for falling-edge detection; idles high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_s1   <= i_rx;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  // State advances at each mid-bit sample point; the edge cycle counts as phase 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RX_IDLE;
      r_phase <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
      case (r_state)
        RX_IDLE: begin
          r_phase <= PW'(1);
          if (r_prev && !w_rx_s) r_state <= RX_START;
        end
        RX_START: begin
          if (w_sample) begin
            if (w_rx_s) begin
              r_state <= RX_IDLE;
            end else begin
              r_state <= RX_DATA;
              r_bit   <= '0;
            end
          end
        end
        RX_DATA: begin
          if (w_sample) begin
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit == BIT_LAST) r_state <= RX_STOP;
            else                   r_bit   <= r_bit + 1'b1;
          end
        end
        RX_STOP: begin
          if (w_sample) begin
            r_state <= RX_IDLE;
            if (w_rx_s) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_ferr  <= 1'b1;
            end
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_ferr;

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 serialiser: start bit, LSB-first data, one stop bit, OVERSAMPLE cycles per bit.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = DEF_DATA_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx
);

  localparam int unsigned PW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  tx_state_t            r_state;
  logic [PW-1:0]        r_phase;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_tx;
  logic                 r_ready;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_bit_end;

  // Next shift-register contents and end-of-bit strobe.
  always_comb begin
    w_shift_nxt = r_shift >> 1;
    w_bit_end   = (r_phase == PH_LAST);
  end

  // Frame sequencer; tx and ready are registered so they change only on state edges.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= TX_IDLE;
      r_phase <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
    end else begin
      r_phase <= w_bit_end ? '0 : r_phase + 1'b1;
      case (r_state)
        TX_IDLE: begin
          r_phase <= '0;
          if (i_valid) begin
            r_state <= TX_START;
            r_shift <= i_data;
            r_tx    <= 1'b0;
            r_ready <= 1'b0;
          end
        end
        TX_START: begin
          if (w_bit_end) begin
            r_state <= TX_DATA;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
          end
        end
        TX_DATA: begin
          if (w_bit_end) begin
            if (r_bit == BIT_LAST) begin
              r_state <= TX_STOP;
              r_tx    <= 1'b1;
              r_ready <= 1'b1;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= w_shift_nxt;
              r_tx    <= w_shift_nxt[0];
            end
          end
        end
        TX_STOP: begin
          if (w_bit_end) begin
            if (i_valid) begin
              r_state <= TX_START;
              r_shift <= i_data;
              r_tx    <= 1'b0;
              r_ready <= 1'b0;
            end else begin
              r_state <= TX_IDLE;
            end
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

  assign o_tx    = r_tx;
  assign o_ready = r_ready;

endmodule

// File: rtl/uart_tx_rx.sv
// UART transmit/receive pair; each direction keeps its own bit-phase counter.
module uart_tx_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err
);

  uart_transmitter #(
    .OVERSAMPLE(OVERSAMPLE),
    .DATA_BITS (DATA_BITS)
  ) u_tx (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_data (tx_data),
    .i_valid(tx_valid),
    .o_ready(tx_ready),
    .o_tx   (tx)
  );

  uart_receiver #(
    .OVERSAMPLE(OVERSAMPLE),
    .DATA_BITS (DATA_BITS)
  ) u_rx (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rx       (rx),
    .o_data     (rx_data),
    .o_valid    (rx_valid),
    .o_frame_err(rx_frame_err)
  );

endmodule

// File: tb/tb_uart_tx_rx.sv
// Directed bench for uart_tx_rx: loopback frames, hand-driven RX frames, glitch and reset corners.
module tb_uart_tx_rx;
  import uart_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       loop;
  logic       rx_drv;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int         c;
    logic [7:0] d;
  } ev_t;
  ev_t vq[$];
  int  fq[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         n_valid;
    int         n_ferr;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vecs[6];

  assign rx = loop ? tx : rx_drv;

  uart_tx_rx #(
    .OVERSAMPLE(8),
    .DATA_BITS (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx          (tx),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) vq.push_back('{c: cyc, d: rx_data});
    if (rx_frame_err) fq.push_back(cyc);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // One-cycle tx_valid pulse; T is the first cycle tx is low.
  task automatic start_tx(input logic [7:0] d, output int t);
    int c0;
    tx_data  = d;
    tx_valid = 1'b1;
    c0 = cyc;
    @(negedge clk);
    t = c0 + 1;
    tx_valid = 1'b0;
    check("tx_latency", 32'(tx), 32'd0);
    check("tx_ready_start", 32'(tx_ready), 32'd0);
  endtask

  // Check all ten bit cells mid-bit; optionally scramble tx_data during DATA.
  task automatic check_tx_bits(input int t, input logic [7:0] d, input logic change, input logic [7:0] alt);
    logic e;
    for (int b = 0; b < 10; b++) begin
      wait_until(t + 8 * b + 4);
      if (change && b == 3) tx_data = alt;
      e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
      check($sformatf("tx_bit%0d", b), 32'(tx), 32'(e));
    end
    check("tx_ready_stop", 32'(tx_ready), 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop, output int c0);
    c0 = cyc;
    for (int b = 0; b < 10; b++) begin
      rx_drv = (b == 0) ? 1'b0 : (b == 9) ? stop : d[b-1];
      repeat (8) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    int t;
    int c0;
    logic prev_rdy;

    vecs[0] = '{data: 8'h81, stop: 1'b1, n_valid: 1, n_ferr: 0, exp_data: 8'h81};
    vecs[1] = '{data: 8'h3C, stop: 1'b0, n_valid: 0, n_ferr: 1, exp_data: 8'h81};
    vecs[2] = '{data: 8'h00, stop: 1'b1, n_valid: 1, n_ferr: 0, exp_data: 8'h00};
    vecs[3] = '{data: 8'hFF, stop: 1'b0, n_valid: 0, n_ferr: 1, exp_data: 8'h00};
    vecs[4] = '{data: 8'h55, stop: 1'b1, n_valid: 1, n_ferr: 0, exp_data: 8'h55};
    vecs[5] = '{data: 8'h7E, stop: 1'b1, n_valid: 1, n_ferr: 0, exp_data: 8'h7E};

    rst_n    = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    loop     = 1'b1;
    rx_drv   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_ferr", 32'(rx_frame_err), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Loopback single frame 0xA5.
    vq.delete(); fq.delete();
    start_tx(8'hA5, t);
    check_tx_bits(t, 8'hA5, 1'b0, 8'h00);
    wait_until(t + 95);
    check("a5_nvalid", 32'(vq.size()), 32'd1);
    if (vq.size() > 0) begin
      check("a5_data", 32'(vq[0].d), 32'hA5);
      check("a5_valid_cycle", 32'(vq[0].c - t), 32'd79);
    end
    check("a5_nferr", 32'(fq.size()), 32'd0);

    // Back-to-back loopback, tx_data += 3 on every tx_ready rise.
    vq.delete(); fq.delete();
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    prev_rdy = 1'b1;
    t = cyc + 1;
    while (cyc < t + 330) begin
      @(negedge clk);
      if (tx_ready && !prev_rdy) tx_data = tx_data + 8'd3;
      prev_rdy = tx_ready;
      if (cyc == t + 250) tx_valid = 1'b0;
      for (int k = 0; k < 4; k++)
        if (cyc == t + 80 * k + 4) check($sformatf("b2b_start%0d", k), 32'(tx), 32'd0);
    end
    check("b2b_idle_tx", 32'(tx), 32'd1);
    check("b2b_idle_ready", 32'(tx_ready), 32'd1);
    check("b2b_nvalid", 32'(vq.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < vq.size()) begin
        check($sformatf("b2b_data%0d", k), 32'(vq[k].d), 32'(3 * k));
        check($sformatf("b2b_cycle%0d", k), 32'(vq[k].c - t), 32'(79 + 80 * k));
      end
    end
    check("b2b_nferr", 32'(fq.size()), 32'd0);

    // Hand-driven RX frames from the vector table.
    loop = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      vq.delete(); fq.delete();
      send_rx(vecs[i].data, vecs[i].stop, c0);
      repeat (16) @(negedge clk);
      check($sformatf("vec%0d_nvalid", i), 32'(vq.size()), 32'(vecs[i].n_valid));
      check($sformatf("vec%0d_nferr", i), 32'(fq.size()), 32'(vecs[i].n_ferr));
      check($sformatf("vec%0d_rx_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
      if (vecs[i].n_valid == 1 && vq.size() == 1)
        check($sformatf("vec%0d_cycle", i), 32'(vq[0].c - c0), 32'd79);
      if (vecs[i].n_ferr == 1 && fq.size() == 1)
        check($sformatf("vec%0d_ferr_cycle", i), 32'(fq[0] - c0), 32'd79);
    end

    // Two-cycle low glitch, then a real 0x81 frame.
    vq.delete(); fq.delete();
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_nvalid", 32'(vq.size()), 32'd0);
    check("glitch_nferr", 32'(fq.size()), 32'd0);
    send_rx(8'h81, 1'b1, c0);
    repeat (16) @(negedge clk);
    check("glitch_next_nvalid", 32'(vq.size()), 32'd1);
    if (vq.size() == 1) begin
      check("glitch_next_data", 32'(vq[0].d), 32'h81);
      check("glitch_next_cycle", 32'(vq[0].c - c0), 32'd79);
    end

    // Reset mid-DATA on a loopback frame, then 0x5A.
    loop = 1'b1;
    repeat (4) @(negedge clk);
    vq.delete(); fq.delete();
    start_tx(8'h33, t);
    wait_until(t + 30);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", 32'(tx), 32'd1);
    check("rst_mid_ready", 32'(tx_ready), 32'd1);
    check("rst_mid_rx_data", 32'(rx_data), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("rst_abort_nvalid", 32'(vq.size()), 32'd0);
    check("rst_abort_nferr", 32'(fq.size()), 32'd0);
    start_tx(8'h5A, t);
    wait_until(t + 95);
    check("rst_next_nvalid", 32'(vq.size()), 32'd1);
    if (vq.size() == 1) begin
      check("rst_next_data", 32'(vq[0].d), 32'h5A);
      check("rst_next_cycle", 32'(vq[0].c - t), 32'd79);
    end

    // tx_data changed mid-frame must not alter the frame in flight.
    vq.delete(); fq.delete();
    start_tx(8'hC3, t);
    check_tx_bits(t, 8'hC3, 1'b1, 8'h00);
    wait_until(t + 95);
    check("latch_nvalid", 32'(vq.size()), 32'd1);
    if (vq.size() == 1) check("latch_data", 32'(vq[0].d), 32'hC3);
    check("frame_len_const", 32'(FRAME_CYCLES), 32'd80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
